// File: rtl/external_interrupt_controller_pkg.sv
// Shared register map and mode encodings for the external interrupt controller.
package external_interrupt_controller_pkg;

  typedef enum logic [1:0] {
    REG_PEND = 2'd0,
    REG_EN   = 2'd1,
    REG_ACK  = 2'd2,
    REG_MODE = 2'd3
  } eic_reg_e;

  localparam logic MODE_EDGE = 1'b1;

endpackage

// File: rtl/external_interrupt_controller_sync_edge_detect.sv
// Per-pin 2-flop synchroniser plus previous-value flop; registered rising-edge and level outputs.
module sync_edge_detect (
  input  logic Sys_Clock,
  input  logic Sys_Reset,
  input  logic Pin,
  output logic Edge,
  output logic Level
);

  logic s1_q, s2_q, prev_q, edge_q, level_q;
  logic s1_d, s2_d, prev_d, edge_d, level_d;

  always_comb begin
    s1_d    = Pin;
    s2_d    = s1_q;
    prev_d  = s2_q;
    edge_d  = s2_q & ~prev_q;
    level_d = s2_q;
  end

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
      level_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      edge_q  <= edge_d;
      level_q <= level_d;
    end
  end

  assign Edge  = edge_q;
  assign Level = level_q;

endmodule

// File: rtl/external_interrupt_controller.sv
// External interrupt controller: pin sync, pending latch, IO register file, lowest-index arbitration.
module external_interrupt_controller
  import external_interrupt_controller_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int ID_W    = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
  input  logic               Sys_Clock,
  input  logic               Sys_Reset,
  input  logic [NUM_SRC-1:0] Irq_Pin,
  input  logic               IO_EnR,
  input  logic               IO_EnW,
  input  logic [1:0]         IO_Addr,
  input  logic [31:0]        IO_DataW,
  output logic [31:0]        IO_DataR,
  output logic               EIC_I_Req,
  output logic [ID_W-1:0]    EIC_I_Id
);

  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (v[i]) lowest_idx = ID_W'(i);
  endfunction

  logic [NUM_SRC-1:0] edge_v, level_v, pend_set, ack_clr, active;
  logic [NUM_SRC-1:0] en_q, en_d, mode_q, mode_d, pend_q, pend_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               req_q, req_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               unused_wdata;

  assign unused_wdata = ^IO_DataW;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    sync_edge_detect u_sync (
      .Sys_Clock (Sys_Clock),
      .Sys_Reset (Sys_Reset),
      .Pin       (Irq_Pin[g]),
      .Edge      (edge_v[g]),
      .Level     (level_v[g])
    );
    assign pend_set[g] = (mode_q[g] == MODE_EDGE) ? edge_v[g] : level_v[g];
  end

  assign active = pend_q & en_q;

  always_comb begin
    en_d    = en_q;
    mode_d  = mode_q;
    ack_clr = '0;
    rdata_d = rdata_q;
    if (IO_EnW) begin
      case (eic_reg_e'(IO_Addr))
        REG_EN:   en_d    = IO_DataW[NUM_SRC-1:0];
        REG_ACK:  ack_clr = IO_DataW[NUM_SRC-1:0];
        REG_MODE: mode_d  = IO_DataW[NUM_SRC-1:0];
        default:  ;
      endcase
    end
    // Set after clear so an edge coinciding with its own ACK is never lost.
    pend_d = (pend_q & ~ack_clr) | pend_set;
    if (IO_EnR) begin
      case (eic_reg_e'(IO_Addr))
        REG_PEND: rdata_d = 32'(pend_q);
        REG_EN:   rdata_d = 32'(en_q);
        REG_ACK:  rdata_d = 32'd0;
        REG_MODE: rdata_d = 32'(mode_q);
        default:  rdata_d = 32'd0;
      endcase
    end
    req_d = |active;
    id_d  = lowest_idx(active);
  end

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      en_q    <= '0;
      mode_q  <= '0;
      pend_q  <= '0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      en_q    <= en_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      id_q    <= id_d;
    end
  end

  assign IO_DataR  = rdata_q;
  assign EIC_I_Req = req_q;
  assign EIC_I_Id  = id_q;

endmodule

// File: tb/tb_external_interrupt_controller.sv
// Directed scoreboard bench for external_interrupt_controller (NUM_SRC=2).
module tb_external_interrupt_controller;

  localparam int NUM_SRC = 2;
  localparam int ID_W    = 1;
  localparam logic [1:0] A_PEND = 2'd0, A_EN = 2'd1, A_ACK = 2'd2, A_MODE = 2'd3;
  localparam int S_DATA = 0, S_REQ = 1, S_ID = 2;

  logic               Sys_Clock = 1'b0;
  logic               Sys_Reset = 1'b0;
  logic [NUM_SRC-1:0] Irq_Pin   = '0;
  logic               IO_EnR    = 1'b0;
  logic               IO_EnW    = 1'b0;
  logic [1:0]         IO_Addr   = '0;
  logic [31:0]        IO_DataW  = '0;
  logic [31:0]        IO_DataR;
  logic               EIC_I_Req;
  logic [ID_W-1:0]    EIC_I_Id;

  external_interrupt_controller #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
    .Sys_Clock (Sys_Clock),
    .Sys_Reset (Sys_Reset),
    .Irq_Pin   (Irq_Pin),
    .IO_EnR    (IO_EnR),
    .IO_EnW    (IO_EnW),
    .IO_Addr   (IO_Addr),
    .IO_DataW  (IO_DataW),
    .IO_DataR  (IO_DataR),
    .EIC_I_Req (EIC_I_Req),
    .EIC_I_Id  (EIC_I_Id)
  );

  always #5 Sys_Clock = ~Sys_Clock;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge Sys_Clock) cyc <= cyc + 1;

  // Monitor: at each falling edge, compare every expectation due at this cycle.
  initial begin
    forever begin
      @(negedge Sys_Clock);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          logic [31:0] act;
          case (sb[i].sel)
            S_DATA:  act = IO_DataR;
            S_REQ:   act = 32'(EIC_I_Req);
            default: act = 32'(EIC_I_Id);
          endcase
          checks++;
          if (act !== sb[i].exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", sb[i].name, cyc, act, sb[i].exp);
          end
          sb.delete(i);
        end
      end
    end
  end

  task automatic push(input int d, input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = cyc + d; e.sel = sel; e.exp = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic exp_req(input int d, input logic r, input logic id, input string nm);
    push(d, S_REQ, 32'(r), {nm, "_req"});
    if (r) push(d, S_ID, 32'(id), {nm, "_id"});
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge Sys_Clock); #2; end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    IO_EnW = 1'b1; IO_Addr = a; IO_DataW = d;
    tick(1);
    IO_EnW = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] v, input string nm);
    IO_EnR = 1'b1; IO_Addr = a;
    push(1, S_DATA, v, nm);
    tick(1);
    IO_EnR = 1'b0;
  endtask

  initial begin
    // 1: reset held with pins toggling
    tick(1);
    for (int i = 0; i < 4; i++) begin
      Irq_Pin = NUM_SRC'(i + 1);
      push(0, S_DATA, 32'd0, "rst_data");
      push(0, S_REQ, 32'd0, "rst_req");
      push(0, S_ID, 32'd0, "rst_id");
      tick(1);
    end
    Irq_Pin = '0;
    Sys_Reset = 1'b1;
    tick(2);
    rd(A_EN, 32'd0, "rst_en");
    rd(A_MODE, 32'd0, "rst_mode");
    rd(A_PEND, 32'd0, "rst_pend");

    // 2: edge latency on pin1
    wr(A_MODE, 32'd3);
    wr(A_EN, 32'd3);
    rd(A_MODE, 32'd3, "mode_rb");
    Irq_Pin[1] = 1'b1;
    exp_req(3, 1'b0, 1'b0, "lat_e3");
    exp_req(4, 1'b0, 1'b0, "lat_e4");
    exp_req(5, 1'b1, 1'b1, "lat_e5");
    tick(1);
    Irq_Pin[1] = 1'b0;
    tick(5);
    rd(A_PEND, 32'd2, "lat_pend");
    rd(A_ACK, 32'd0, "ack_reads0");
    exp_req(1, 1'b1, 1'b1, "ack2_hold");
    exp_req(2, 1'b0, 1'b0, "ack2_drop");
    wr(A_ACK, 32'd2);
    tick(2);

    // 3: priority between two pending sources
    Irq_Pin = 2'b11;
    tick(1);
    Irq_Pin = 2'b00;
    tick(6);
    rd(A_PEND, 32'd3, "prio_pend");
    exp_req(0, 1'b1, 1'b0, "prio_both");
    exp_req(2, 1'b1, 1'b1, "prio_next");
    wr(A_ACK, 32'd1);
    exp_req(2, 1'b0, 1'b0, "prio_none");
    wr(A_ACK, 32'd2);
    tick(2);

    // 4: level re-assert
    wr(A_MODE, 32'd0);
    wr(A_EN, 32'd1);
    Irq_Pin[0] = 1'b1;
    tick(6);
    exp_req(0, 1'b1, 1'b0, "lvl_on");
    wr(A_ACK, 32'd1);
    exp_req(1, 1'b1, 1'b0, "lvl_hold1");
    exp_req(3, 1'b1, 1'b0, "lvl_hold3");
    rd(A_PEND, 32'd1, "lvl_repend");
    Irq_Pin[0] = 1'b0;
    tick(4);
    exp_req(2, 1'b0, 1'b0, "lvl_off");
    wr(A_ACK, 32'd1);
    tick(2);
    rd(A_PEND, 32'd0, "lvl_clear");

    // 5: edge set colliding with its own ACK
    wr(A_MODE, 32'd1);
    Irq_Pin[0] = 1'b1;
    tick(3);
    wr(A_ACK, 32'd1);
    rd(A_PEND, 32'd1, "coll_pend");
    exp_req(0, 1'b1, 1'b0, "coll_req");
    Irq_Pin[0] = 1'b0;
    wr(A_ACK, 32'd1);
    tick(2);

    // 6: masking and IO read/write overlap
    wr(A_EN, 32'd0);
    wr(A_MODE, 32'd3);
    Irq_Pin[1] = 1'b1;
    tick(1);
    Irq_Pin[1] = 1'b0;
    tick(6);
    exp_req(0, 1'b0, 1'b0, "mask_req");
    rd(A_PEND, 32'd2, "mask_pend");
    exp_req(1, 1'b0, 1'b0, "en_wr_edge");
    exp_req(2, 1'b1, 1'b1, "en_wr_next");
    wr(A_EN, 32'd2);
    tick(1);
    IO_EnR = 1'b1; IO_EnW = 1'b1; IO_Addr = A_EN; IO_DataW = 32'd0;
    push(1, S_DATA, 32'd2, "rw_data");
    exp_req(1, 1'b1, 1'b1, "rw_hold");
    exp_req(2, 1'b0, 1'b0, "rw_drop");
    tick(1);
    IO_EnR = 1'b0; IO_EnW = 1'b0;
    tick(2);
    rd(A_EN, 32'd0, "rw_en_after");

    // Drain scoreboard within a bounded number of cycles
    for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
    if (sb.size() > 0) begin
      errors += sb.size();
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
